// File: rtl/gray_counter.sv
// Up/down binary counter with synchronous load, wrap pulse and a Gray-coded copy of the count.
// Define GRAY_REG_OUT_EN to register the Gray output; otherwise it is decoded combinationally from b.
module gray_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic [W-1:0] b,
    output logic [W-1:0] g,
    output logic         wrap
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         wrap_q;
    logic         wrap_d;

    function automatic logic [W-1:0] toGray(input logic [W-1:0] x);
        return x ^ (x >> 1);
    endfunction

    // Load wins over counting; wrap flags the step that crosses the all-ones/all-zeros boundary.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (load) begin
            cnt_d = din;
        end else if (en) begin
            if (up) begin
                cnt_d  = cnt_q + ONE;
                wrap_d = (cnt_q == '1);
            end else begin
                cnt_d  = cnt_q - ONE;
                wrap_d = (cnt_q == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

`ifdef GRAY_REG_OUT_EN
    logic [W-1:0] g_q;

    // Encoding the next count keeps the registered Gray value aligned with b in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q <= '0;
        end else begin
            g_q <= toGray(cnt_d);
        end
    end

    assign g = g_q;
`else
    assign g = toGray(cnt_q);
`endif

    assign b    = cnt_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed self-checking bench for gray_counter (W=4): reset, sweeps, wraps, load priority,
// direction change and hold, with immediate assertions at every comparison point.
module tb_gray_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] din;
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic         wrap;

    int vectors     = 0;
    int miscompares = 0;

    gray_counter #(.W(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .up   (up),
        .load (load),
        .din  (din),
        .b    (b),
        .g    (g),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [W-1:0] grayOf(input logic [W-1:0] x);
        return x ^ (x >> 1);
    endfunction

    task automatic checkValue(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] expB,
                               input logic [W-1:0] expG, input logic expWrap);
        checkValue({tag, ".b"}, b, expB);
        checkValue({tag, ".g"}, g, expG);
        checkBit({tag, ".wrap"}, wrap, expWrap);
    endtask

    task automatic checkOneBit(input string tag, input logic [W-1:0] prevG);
        vectors++;
        assert ($countones(prevG ^ g) == 1) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0d bits changed expected=1", tag, $countones(prevG ^ g));
        end
    endtask

    // Drive inputs on the falling edge, then sample just after the following rising edge.
    task automatic applyStimulus(input logic l, input logic [W-1:0] d, input logic e, input logic u);
        @(negedge clk);
        load = l;
        din  = d;
        en   = e;
        up   = u;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] prevG;
        logic [W-1:0] expB;

        rst_n = 1'b1;
        load  = 1'b0;
        en    = 1'b0;
        up    = 1'b0;
        din   = '0;
        #1 rst_n = 1'b0;
        #1 checkOutput("reset_async", 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 1; i <= 17; i++) begin
            prevG = g;
            applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);
            expB = i[W-1:0];
            checkOutput($sformatf("up_sweep%0d", i), expB, grayOf(expB), expB == 4'b0000);
            checkOneBit($sformatf("up_onebit%0d", i), prevG);
        end
        checkValue("up_sweep_end_g", g, 4'b0001);

        applyStimulus(1'b1, 4'd9, 1'b0, 1'b0);
        checkOutput("load9", 4'd9, 4'b1101, 1'b0);
        #2 rst_n = 1'b0;
        #1 checkOutput("reset_mid", 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b1010, 1'b1, 1'b1);
        checkOutput("reset_ignore", 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        load  = 1'b0;
        en    = 1'b1;
        up    = 1'b1;
        @(posedge clk);
        #1 checkOutput("post_reset", 4'd1, 4'b0001, 1'b0);

        applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0);
        checkOutput("dn_load1", 4'd1, 4'b0001, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("dn_0", 4'd0, 4'b0000, 1'b0);
        prevG = g;
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("dn_wrap", 4'd15, 4'b1000, 1'b1);
        checkOneBit("dn_wrap_onebit", prevG);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("dn_hold", 4'd15, 4'b1000, 1'b0);

        applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
        checkOutput("load5", 4'd5, 4'b0111, 1'b0);
        applyStimulus(1'b1, 4'b1010, 1'b1, 1'b1);
        checkOutput("load_prio", 4'b1010, 4'b1111, 1'b0);
        applyStimulus(1'b1, 4'd15, 1'b0, 1'b0);
        checkOutput("load15", 4'd15, 4'b1000, 1'b0);
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b1);
        checkOutput("load_no_wrap", 4'd0, 4'b0000, 1'b0);

        applyStimulus(1'b1, 4'd7, 1'b0, 1'b0);
        checkOutput("load7", 4'd7, 4'b0100, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);
        checkOutput("dir_up", 4'd8, 4'b1100, 1'b0);
        prevG = g;
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("dir_dn1", 4'd7, 4'b0100, 1'b0);
        checkOneBit("dir_dn1_onebit", prevG);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("dir_dn2", 4'd6, 4'b0101, 1'b0);

        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
        checkOutput("load3", 4'd3, 4'b0010, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1);
            checkOutput($sformatf("hold%0d", i), 4'd3, 4'b0010, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
